// File: rtl/lane_evt_pkg.sv
// Shared types and defaults for the lane event collector.
// Optional timestamp field is present only when LANE_EVT_TIMESTAMP_EN is defined.
package lane_evt_pkg;

   localparam int DEF_NUM_LANES = 10;
   localparam int DEF_CNT_W     = 8;

   // Record fields are sized for the largest legal configuration; the top slices them down.
   localparam int REC_LANE_W    = 5;
   localparam int REC_CNT_W     = 32;
`ifdef LANE_EVT_TIMESTAMP_EN
   localparam int DEF_TS_W      = 16;
   localparam int REC_TS_W      = 32;
`endif

   typedef enum logic {
      ST_IDLE,
      ST_HOLD
   } state_t;

   typedef struct packed {
      logic [REC_LANE_W-1:0] lane;
      logic [REC_CNT_W-1:0]  count;
`ifdef LANE_EVT_TIMESTAMP_EN
      logic [REC_TS_W-1:0]   ts;
`endif
   } lane_rec_t;

   function automatic int wrap_add(input int a, input int b, input int n);
      return (a + b >= n) ? (a + b - n) : (a + b);
   endfunction

endpackage

// File: rtl/lane_rr_arbiter.sv
// Round-robin lane arbiter: picks the first requesting lane at or after the pointer.
// The one-hot grant is asserted only while the advance strobe is high.
module lane_rr_arbiter
   import lane_evt_pkg::*;
#(
   parameter int NUM_LANES = DEF_NUM_LANES,
   localparam int LANE_W   = $clog2(NUM_LANES)
) (
   input  logic [NUM_LANES-1:0] i_req,
   input  logic [LANE_W-1:0]    i_ptr,
   input  logic                 i_adv,
   output logic [NUM_LANES-1:0] o_gnt,
   output logic [LANE_W-1:0]    o_gnt_idx,
   output logic                 o_any
);

   always_comb begin
      logic [LANE_W-1:0] v_idx;
      v_idx     = '0;
      o_gnt_idx = '0;
      o_gnt     = '0;
      o_any     = |i_req;
      // Scan from farthest to nearest so the closest requester after the pointer wins.
      for (int k = NUM_LANES - 1; k >= 0; k--) begin
         v_idx = LANE_W'(wrap_add(int'(i_ptr), k, NUM_LANES));
         if (i_req[v_idx]) begin
            o_gnt_idx = v_idx;
         end
      end
      if (i_adv && o_any) begin
         o_gnt[o_gnt_idx] = 1'b1;
      end
   end

endmodule

// File: rtl/lane_event_collector.sv
// Counts per-lane event pulses and serialises them as (lane, count) records on a valid/ready stream.
// Define LANE_EVT_TIMESTAMP_EN to add TS_W and out_ts_o (free-running counter captured at each load).
module lane_event_collector
   import lane_evt_pkg::*;
#(
   parameter int NUM_LANES = DEF_NUM_LANES,
   parameter int CNT_W     = DEF_CNT_W,
`ifdef LANE_EVT_TIMESTAMP_EN
   parameter int TS_W      = DEF_TS_W,
`endif
   localparam int LANE_W   = $clog2(NUM_LANES)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_LANES-1:0] lane_evt_i,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic [LANE_W-1:0]    out_lane_o,
   output logic [CNT_W-1:0]     out_count_o,
`ifdef LANE_EVT_TIMESTAMP_EN
   output logic [TS_W-1:0]      out_ts_o,
`endif
   output logic [NUM_LANES-1:0] overflow_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t                          r_state;
   state_t                          w_state_next;
   lane_rec_t                       r_rec;
   logic [LANE_W-1:0]               r_ptr;
   logic [NUM_LANES-1:0]            w_req;
   logic [NUM_LANES-1:0]            w_gnt;
   logic [LANE_W-1:0]               w_gnt_idx;
   logic                            w_any;
   logic                            w_load;
   logic [NUM_LANES-1:0][CNT_W-1:0] w_cnt;
   logic [NUM_LANES-1:0]            w_ovf;
   logic                            w_rec_unused;

   for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      logic [CNT_W-1:0] r_cnt;
      logic             r_ovf;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_cnt <= '0;
            r_ovf <= 1'b0;
         end else if (w_gnt[gi]) begin
            // Drained lane restarts from this cycle's event so none is lost.
            r_cnt <= lane_evt_i[gi] ? CNT_W'(1) : '0;
         end else if (lane_evt_i[gi]) begin
            if (r_cnt == CNT_MAX) begin
               r_ovf <= 1'b1;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end
      end

      assign w_cnt[gi] = r_cnt;
      assign w_req[gi] = (r_cnt != '0);
      assign w_ovf[gi] = r_ovf;
   end

   lane_rr_arbiter #(
      .NUM_LANES (NUM_LANES)
   ) u_arb (
      .i_req     (w_req),
      .i_ptr     (r_ptr),
      .i_adv     (w_load),
      .o_gnt     (w_gnt),
      .o_gnt_idx (w_gnt_idx),
      .o_any     (w_any)
   );

   always_comb begin
      w_state_next = r_state;
      w_load       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_any) begin
               w_load       = 1'b1;
               w_state_next = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (out_ready_i) begin
               if (w_any) begin
                  w_load = 1'b1;
               end else begin
                  w_state_next = ST_IDLE;
               end
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

`ifdef LANE_EVT_TIMESTAMP_EN
   logic [TS_W-1:0] r_ts;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ts <= '0;
      end else begin
         r_ts <= r_ts + 1'b1;
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_ptr   <= '0;
         r_rec   <= '0;
      end else begin
         r_state <= w_state_next;
         if (w_load) begin
            r_rec.lane  <= REC_LANE_W'(w_gnt_idx);
            r_rec.count <= REC_CNT_W'(w_cnt[w_gnt_idx]);
`ifdef LANE_EVT_TIMESTAMP_EN
            r_rec.ts    <= REC_TS_W'(r_ts);
`endif
            r_ptr <= (w_gnt_idx == LANE_W'(NUM_LANES - 1)) ? '0 : w_gnt_idx + 1'b1;
         end
      end
   end

   assign out_valid_o  = (r_state == ST_HOLD);
   assign out_lane_o   = r_rec.lane[LANE_W-1:0];
   assign out_count_o  = r_rec.count[CNT_W-1:0];
`ifdef LANE_EVT_TIMESTAMP_EN
   assign out_ts_o     = r_rec.ts[TS_W-1:0];
`endif
   assign overflow_o   = w_ovf;
   assign w_rec_unused = ^r_rec;

endmodule
